// File: rtl/pc_redirect_if.sv
// Fetch/resolve signal bundle between the pipeline and the PC redirect unit.
// The master side drives fetch and resolve requests; the slave side returns the PC and status.
interface pc_redirect_if #(
  parameter int XLEN = 32
);
  logic            clk_enable;
  logic            IF_stall;
  logic            IF_is_branch;
  logic            branch_estimation;
  logic [XLEN-1:0] branch_target;
  logic            EX_branch;
  logic            EX_branch_taken;
  logic [XLEN-1:0] EX_branch_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] IF_pc;
  logic            flush;
  logic            mispredict;
  logic            queue_full;
  logic            error;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output clk_enable, IF_stall, IF_is_branch, branch_estimation, branch_target,
           EX_branch, EX_branch_taken, EX_branch_target, trap_valid, trap_target,
    input  IF_pc, flush, mispredict, queue_full, error, branch_count, mispredict_count
  );

  modport slave (
    input  clk_enable, IF_stall, IF_is_branch, branch_estimation, branch_target,
           EX_branch, EX_branch_taken, EX_branch_target, trap_valid, trap_target,
    output IF_pc, flush, mispredict, queue_full, error, branch_count, mispredict_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with next-PC selection, in-flight prediction queue,
// mispredict/trap flush generation and saturating branch performance counters.
module pc_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input logic          clk,
  input logic          reset,
  pc_redirect_if.slave bus
);
  localparam int              PW       = $clog2(QDEPTH);
  localparam logic [PW:0]     DEPTH    = (PW+1)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [31:0]     CNT_MAX  = '1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [QDEPTH-1:0] pred_q, pred_d;
  logic [XLEN-1:0] fall_q [QDEPTH];
  logic [XLEN-1:0] fall_d [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            error_q, error_d;
  logic [31:0]     br_cnt_q, br_cnt_d;
  logic [31:0]     mp_cnt_q, mp_cnt_d;

  logic            empty, full, head_pred, mispredict, flush;
  logic            push, pop, push_ok;
  logic [XLEN-1:0] head_fall;

  // An empty queue behaves as a not-taken prediction, so only a taken outcome redirects.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DEPTH);
    head_pred  = pred_q[rd_ptr_q];
    head_fall  = fall_q[rd_ptr_q];
    mispredict = bus.EX_branch &
                 (empty ? bus.EX_branch_taken : (bus.EX_branch_taken != head_pred));
    flush      = bus.trap_valid | mispredict;
    pop        = bus.clk_enable & bus.EX_branch & ~empty;
    push       = bus.clk_enable & bus.IF_is_branch & ~bus.IF_stall & ~flush;
    push_ok    = push & (~full | pop);
  end

  always_comb begin
    pc_d     = pc_q;
    pred_d   = pred_q;
    fall_d   = fall_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (bus.clk_enable) begin
      if (bus.trap_valid)
        pc_d = bus.trap_target;
      else if (mispredict)
        pc_d = bus.EX_branch_taken ? bus.EX_branch_target : head_fall;
      else if (bus.IF_stall)
        pc_d = pc_q;
      else if (bus.IF_is_branch && bus.branch_estimation)
        pc_d = bus.branch_target;
      else
        pc_d = pc_q + PC_STEP;

      if (bus.EX_branch && br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict && mp_cnt_q != CNT_MAX)    mp_cnt_d = mp_cnt_q + 32'd1;
      if ((push && !push_ok) || (bus.EX_branch && empty)) error_d = 1'b1;

      // Everything queued behind a redirect is wrong-path, so the whole queue goes.
      if (flush) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) begin
          pred_d[wr_ptr_q] = bus.branch_estimation;
          fall_d[wr_ptr_q] = pc_q + PC_STEP;
          wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      pred_q   <= '0;
      fall_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      pred_q   <= pred_d;
      fall_q   <= fall_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bus.IF_pc            = pc_q;
  assign bus.flush            = flush;
  assign bus.mispredict       = mispredict;
  assign bus.queue_full       = full;
  assign bus.error            = error_q;
  assign bus.branch_count     = br_cnt_q;
  assign bus.mispredict_count = mp_cnt_q;
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the fetch PC register and selects next PC each cycle from: misprediction redirect, trap redirect, stall hold, branch-predictor estimate, sequential PC+4.
- Sits between branch_predictor (consumes branch_estimation/branch_target) and instruction memory (drives IF_pc); tracks in-flight predictions until EX resolves them.
- Raises pipeline flush on mispredict; keeps branch/mispredict performance counters.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- QDEPTH, 4, in-flight prediction queue depth (power of 2, >=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_enable  in  1  global advance qualifier; no state changes when 0
- IF_stall  in  1  hold PC, no queue push
- IF_is_branch  in  1  instruction at IF_pc is a conditional branch
- branch_estimation  in  1  predictor taken estimate for IF_pc
- branch_target  in  XLEN  predicted target for IF_pc
- EX_branch  in  1  branch resolving in EX this cycle
- EX_branch_taken  in  1  actual outcome
- EX_branch_target  in  XLEN  actual taken target
- trap_valid  in  1  trap/exception redirect request
- trap_target  in  XLEN  trap vector
- IF_pc  out  XLEN  current fetch PC (registered)
- flush  out  1  kill IF/ID/EX-younger instructions (combinational)
- mispredict  out  1  EX resolution disagreed with queued prediction (combinational)
- queue_full  out  1  prediction queue holds QDEPTH entries
- error  out  1  sticky: overflow push or underflow pop
- branch_count  out  32  resolved branches, saturating
- mispredict_count  out  32  mispredictions, saturating

Behaviour:
- Reset (reset=0, async): IF_pc=RESET_PC; queue empty (rd/wr pointers 0, count 0); error=0; both counters 0. flush/mispredict=0 as combinational consequence.
- Queue entry = {pred_taken, fallthrough_pc = IF_pc+4}. Push on rising clk when clk_enable & IF_is_branch & !IF_stall & !flush & !trap_valid.
- Pop head when clk_enable & EX_branch. mispredict = EX_branch & (EX_branch_taken != head.pred_taken); evaluated combinationally against current head.
- Next-PC priority (registered on clk when clk_enable=1):
  1. trap_valid -> trap_target; flush=1; queue cleared.
  2. mispredict -> EX_branch_taken ? EX_branch_target : head.fallthrough_pc; flush=1; queue cleared (younger entries are wrong-path).
  3. IF_stall -> hold IF_pc.
  4. IF_is_branch & branch_estimation -> branch_target.
  5. else IF_pc+4 (modulo 2^XLEN, wraps silently).
- Redirect/flush take effect next cycle: IF_pc updated one clock after the request cycle; flush asserted in request cycle only.
- Correct prediction: pop only, no flush, PC follows rules 3-5.
- Simultaneous push and pop (no flush): count unchanged, both pointers advance.
- Full: push while count==QDEPTH and no same-cycle pop -> entry dropped, error set. Push+pop when full is legal.
- Empty: EX_branch with empty queue -> treated as predicted not-taken with fallthrough unknown; if EX_branch_taken=1 redirect to EX_branch_target with flush; if 0 no redirect; error set in both cases; pointers unchanged.
- Counters: branch_count +1 per EX_branch (when clk_enable); mispredict_count +1 per mispredict; both saturate at 32'hFFFF_FFFF. Trap does not count.
- clk_enable=0: all registers hold; flush/mispredict still driven combinationally but no state effect.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk/clk_enable.
- IF_pc low two bits are never forced; alignment checking is outside this block.

Test Plan:
- Reset release, no branches, clk_enable=1 for 4 cycles -> IF_pc 0x0,0x4,0x8,0xC; counters 0; flush never asserted.
- Branch at 0x10 predicted taken to 0x40, EX resolves taken 2 cycles later -> IF_pc 0x40 next cycle, no flush, branch_count=1, mispredict_count=0, queue empty.
- Branch at 0x10 predicted taken to 0x40, EX resolves not-taken -> flush=1 that cycle, IF_pc=0x14 next cycle, mispredict_count=1, queue empty.
- Branch at 0x20 predicted not-taken, EX resolves taken to 0x80 while second branch queued -> flush, IF_pc=0x80, both entries discarded, count 0.
- Push 4 predictions with no EX pops then 5th branch -> queue_full=1, error=1 sticky, IF_pc still advances per prediction; reset low -> error=0, IF_pc=RESET_PC.
- trap_valid=1 (target 0x100) same cycle as mispredict -> IF_pc=0x100, flush=1, mispredict_count still increments, queue cleared; IF_stall=1 with no redirect -> IF_pc held, no push.
